alu_issue_ctrl: RTL and testbench

Upstream issue stage for the 4-bit/3-bit-op combinational ALU (8-bit result). It accepts operand/opcode triples over a valid/ready handshake and buffers them in a small FIFO. It drives one triple at a time onto registered ALU operand lines, captures the ALU result one cycle later, and presents it downstream over a valid/ready handshake. It decouples bursty producers from the ALU and gives the ALU registered, glitch-free inputs.

---
 rtl/alu_issue_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - FIFO-buffered issue stage that feeds registered operands to a combinational ALU
module alu_issue_ctrl #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    input  logic [2:0] in_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [7:0] alu_res,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic [2:0] res_op,
    output logic       busy,
    output logic [7:0] done_cnt
);

    // Entry layout: {op, a, b}
    localparam int ENTRY_W = 11;
    localparam logic [PTR_W:0] LP_DEPTH = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;

    logic [3:0] r_alu_a;
    logic [3:0] r_alu_b;
    logic [2:0] r_alu_op;
    logic       r_res_valid;
    logic [7:0] r_res_data;
    logic [2:0] r_res_op;
    logic [7:0] r_done_cnt;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_capture;
    logic               w_accept;
    logic [ENTRY_W-1:0] w_head;

    assign w_full  = (r_count == LP_DEPTH);
    assign w_empty = (r_count == '0);
    assign w_head  = r_mem[r_rd_ptr];

    // Readiness looks only at registered occupancy, so a full FIFO refuses
    // input even on a cycle where it is also popping. Held low during reset.
    assign in_ready = rst_n && !w_full;
    assign w_push   = in_valid && in_ready;

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_op    = r_res_op;
    assign done_cnt  = r_done_cnt;
    assign busy      = (r_state != S_IDLE) || !w_empty;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state: idle until work exists, issue for one cycle, hold until accepted
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_next_state = S_HOLD;
            end
            S_HOLD: begin
                if (res_ready) begin
                    w_next_state = w_empty ? S_IDLE : S_ISSUE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // FSM outputs: when to pop the FIFO, capture the ALU result, and retire a result
    always_comb begin
        w_pop     = 1'b0;
        w_capture = 1'b0;
        w_accept  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_pop = !w_empty;
            end
            S_ISSUE: begin
                w_capture = 1'b1;
            end
            S_HOLD: begin
                w_accept = res_ready;
                w_pop    = res_ready && !w_empty;
            end
            default: begin
                w_pop     = 1'b0;
                w_capture = 1'b0;
                w_accept  = 1'b0;
            end
        endcase
    end

    // FIFO storage; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_op, in_a, in_b};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Operand registers change only on a pop so the ALU inputs stay glitch-free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= '0;
        end else if (w_pop) begin
            r_alu_op <= w_head[10:8];
            r_alu_a  <= w_head[7:4];
            r_alu_b  <= w_head[3:0];
        end
    end

    // Result capture one cycle after issue; valid drops when the consumer takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_op    <= '0;
        end else if (w_capture) begin
            r_res_valid <= 1'b1;
            r_res_data  <= alu_res;
            r_res_op    <= r_alu_op;
        end else if (w_accept) begin
            r_res_valid <= 1'b0;
        end
    end

    // Completed-result counter, wraps modulo 256
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done_cnt <= '0;
        end else if (w_accept) begin
            r_done_cnt <= r_done_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [2:0] in_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_res;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [2:0] res_op;
    logic       busy;
    logic [7:0] done_cnt;

    int n_total;
    int n_pass;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
    } trip_t;

    trip_t push_q[$];
    trip_t exp_q[$];

    alu_issue_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_res   (alu_res),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_op    (res_op),
        .busy      (busy),
        .done_cnt  (done_cnt)
    );

    // ALU stub: result is the concatenation of the operands
    assign alu_res = {alu_a, alu_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic enqueue(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op, input bit expect_result);
        trip_t t;
        t.a = a;
        t.b = b;
        t.op = op;
        push_q.push_back(t);
        if (expect_result) exp_q.push_back(t);
    endtask

    // Drives queued triples as a producer and checks accepted results as a consumer
    task automatic run(input int cycles, input bit until_done);
        int    n;
        bit    will_push;
        trip_t t;
        trip_t e;
        n = 0;
        while (n < cycles && !(until_done && exp_q.size() == 0 && push_q.size() == 0 && !in_valid)) begin
            @(negedge clk);
            if (!in_valid && push_q.size() > 0) begin
                t = push_q.pop_front();
                in_a = t.a;
                in_b = t.b;
                in_op = t.op;
                in_valid = 1'b1;
            end
            will_push = in_valid && in_ready;
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_result", 32'(res_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("res_data", 32'(res_data), 32'({e.a, e.b}));
                    check("res_op", 32'(res_op), 32'(e.op));
                end
            end
            @(posedge clk);
            #1;
            if (will_push) in_valid = 1'b0;
            n++;
        end
        if (until_done) check("timeout_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        push_q.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        logic [7:0] iv;
        n_total = 0;
        n_pass = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_op = '0;
        res_ready = 1'b0;

        // Reset state
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_done_cnt", 32'(done_cnt), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);

        // Single op with latency checks
        res_ready = 1'b1;
        @(negedge clk);
        in_a = 4'h4;
        in_b = 4'hC;
        in_op = 3'd0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("single_k0_res_valid", 32'(res_valid), 32'd0);
        @(posedge clk);
        #1;
        check("single_k1_alu_a", 32'(alu_a), 32'h4);
        check("single_k1_alu_b", 32'(alu_b), 32'hC);
        check("single_k1_res_valid", 32'(res_valid), 32'd0);
        @(posedge clk);
        #1;
        check("single_k2_res_valid", 32'(res_valid), 32'd1);
        check("single_res_data", 32'(res_data), 32'h4C);
        check("single_res_op", 32'(res_op), 32'd0);
        @(posedge clk);
        #1;
        check("single_done_cnt", 32'(done_cnt), 32'd1);
        check("single_busy", 32'(busy), 32'd0);
        check("single_res_valid_cleared", 32'(res_valid), 32'd0);

        // Back-pressure plus full-FIFO refusal of a held triple
        res_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            iv = 8'(i);
            enqueue(iv[3:0], 4'hF, iv[2:0], 1'b1);
        end
        enqueue(4'hA, 4'hA, 3'd6, 1'b1);
        run(10, 1'b0);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_res_valid", 32'(res_valid), 32'd1);
        check("bp_res_data_held", 32'(res_data), 32'h1F);
        check("bp_res_op_held", 32'(res_op), 32'd1);
        check("bp_alu_a_held", 32'(alu_a), 32'd1);
        run(3, 1'b0);
        check("bp_res_data_stable", 32'(res_data), 32'h1F);
        check("bp_in_ready_still_low", 32'(in_ready), 32'd0);
        res_ready = 1'b1;
        run(200, 1'b1);
        run(4, 1'b0);
        check("bp_done_cnt", 32'(done_cnt), 32'd7);
        check("bp_busy", 32'(busy), 32'd0);

        // Wrap-around streaming
        do_reset();
        check("wrap_rst_done_cnt", 32'(done_cnt), 32'd0);
        res_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            iv = 8'(i);
            enqueue(iv[3:0], ~iv[3:0], iv[2:0], 1'b1);
        end
        run(400, 1'b1);
        run(3, 1'b0);
        check("wrap_done_cnt", 32'(done_cnt), 32'd20);
        check("wrap_busy", 32'(busy), 32'd0);

        // Reset in the middle of operation
        res_ready = 1'b0;
        enqueue(4'h7, 4'h1, 3'd2, 1'b0);
        enqueue(4'h8, 4'h2, 3'd3, 1'b0);
        enqueue(4'h9, 4'h3, 3'd4, 1'b0);
        run(6, 1'b0);
        check("mid_pre_res_valid", 32'(res_valid), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_in_ready", 32'(in_ready), 32'd0);
        check("mid_res_valid", 32'(res_valid), 32'd0);
        check("mid_res_data", 32'(res_data), 32'd0);
        check("mid_res_op", 32'(res_op), 32'd0);
        check("mid_alu_a", 32'(alu_a), 32'd0);
        check("mid_alu_b", 32'(alu_b), 32'd0);
        check("mid_alu_op", 32'(alu_op), 32'd0);
        check("mid_done_cnt", 32'(done_cnt), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_post_in_ready", 32'(in_ready), 32'd1);
        res_ready = 1'b1;
        run(6, 1'b0);
        check("mid_no_stale", 32'(done_cnt), 32'd0);
        enqueue(4'h2, 4'h6, 3'd5, 1'b1);
        run(50, 1'b1);
        run(2, 1'b0);
        check("mid_new_done_cnt", 32'(done_cnt), 32'd1);

        // Counter wrap: 255 more results brings the total to 256
        for (int i = 0; i < 254; i++) begin
            iv = 8'(i);
            enqueue(iv[3:0], iv[7:4], iv[2:0], 1'b1);
        end
        run(2000, 1'b1);
        run(2, 1'b0);
        check("cnt_255", 32'(done_cnt), 32'd255);
        enqueue(4'hE, 4'h1, 3'd7, 1'b1);
        run(50, 1'b1);
        run(2, 1'b0);
        check("cnt_wrap_0", 32'(done_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
